dsp_pair_loader: RTL and testbench

//  Writer side of the DSP operand memory: accepts a byte stream over a valid/ready

---
 rtl/dsp_pair_loader.sv | 103 ++++++++++
 tb/tb_dsp_pair_loader.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dsp_pair_loader.sv
// Byte-stream to (a,b) pair-memory loader for the DSP operand memory.
// Collects pairs, writes them one per cycle, launches a DSP run and waits for done.
module dsp_pair_loader #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data_a,
  output logic [DATA_W-1:0] wr_data_b,
  output logic              start,
  output logic [ADDR_W:0]   pair_count,
  input  logic              dsp_done,
  output logic              busy,
  output logic              err_odd,
  output logic [2:0]        dbg_state
);

  // Handshake: a byte moves on a rising edge where in_valid && in_ready; in_ready
  // depends only on state, so the source holds in_data/in_last until it is taken.

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] LOAD_A = 3'd1;
  localparam logic [2:0] LOAD_B = 3'd2;
  localparam logic [2:0] WRITE  = 3'd3;
  localparam logic [2:0] START  = 3'd4;
  localparam logic [2:0] WAIT   = 3'd5;

  localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W+1)'(DEPTH);

  logic [2:0]        state;
  logic [DATA_W-1:0] a_reg;
  logic              last_flag;
  logic [ADDR_W:0]   count_next;

  assign count_next = pair_count + 1'b1;

  assign in_ready  = (state == LOAD_A) || (state == LOAD_B);
  assign wr_en     = (state == WRITE);
  assign start     = (state == START);
  assign busy      = (state == START) || (state == WAIT);
  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      a_reg      <= '0;
      last_flag  <= 1'b0;
      wr_addr    <= '0;
      wr_data_a  <= '0;
      wr_data_b  <= '0;
      pair_count <= '0;
      err_odd    <= 1'b0;
    end else begin
      err_odd <= 1'b0;
      case (state)
        IDLE: state <= LOAD_A;
        LOAD_A: begin
          if (in_valid) begin
            a_reg <= in_data;
            if (in_last) begin
              // Unpaired a byte closes the run; it is dropped and flagged.
              err_odd <= 1'b1;
              if (pair_count != '0) state <= START;
            end else begin
              state <= LOAD_B;
            end
          end
        end
        LOAD_B: begin
          if (in_valid) begin
            // Write port registers are loaded here so they hold between writes.
            wr_addr   <= pair_count[ADDR_W-1:0];
            wr_data_a <= a_reg;
            wr_data_b <= in_data;
            last_flag <= in_last;
            state     <= WRITE;
          end
        end
        WRITE: begin
          pair_count <= count_next;
          state      <= (last_flag || (count_next == FULL_COUNT)) ? START : LOAD_A;
        end
        START: state <= WAIT;
        WAIT: begin
          if (dsp_done) begin
            pair_count <= '0;
            state      <= LOAD_A;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dsp_pair_loader.sv
// Directed + random stream bench for dsp_pair_loader with a pair/run reference model,
// a write scoreboard and a background DSP responder.
module tb_dsp_pair_loader;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;
  localparam int WE_W   = ADDR_W + 2*DATA_W;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              in_valid = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_last = 1'b0;
  logic              in_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data_a;
  logic [DATA_W-1:0] wr_data_b;
  logic              start;
  logic [ADDR_W:0]   pair_count;
  logic              dsp_done = 1'b0;
  logic              busy;
  logic              err_odd;
  logic [2:0]        dbg_state;

  dsp_pair_loader #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data_a(wr_data_a),
    .wr_data_b(wr_data_b), .start(start), .pair_count(pair_count), .dsp_done(dsp_done),
    .busy(busy), .err_odd(err_odd), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // reference model: expected writes, expected run starts, expected odd-byte errors
  logic [WE_W-1:0]   exp_q[$];
  logic [ADDR_W:0]   start_q[$];
  int                exp_err = 0;
  bit                have_a  = 0;
  logic [DATA_W-1:0] model_a;
  int                cnt     = 0;
  int                last_wait = 0;

  // scoreboard monitor
  initial begin
    forever begin
      @(negedge clk);
      if (wr_en) begin
        if (exp_q.size() == 0) check("wr_unexp", wr_en, 0);
        else check("wr_pair", {wr_addr, wr_data_a, wr_data_b}, exp_q.pop_front());
      end
      if (start) begin
        if (start_q.size() == 0) check("start_unexp", start, 0);
        else check("start_count", pair_count, start_q.pop_front());
      end
      if (err_odd) begin
        if (exp_err == 0) check("err_unexp", err_odd, 0);
        else begin exp_err--; check("err_pulse", err_odd, 1); end
      end
      if (busy) check("ready_busy", in_ready, 0);
    end
  end

  // DSP responder: answers done a random number of cycles into WAIT
  bit auto_done = 1'b1;
  bit done_chk  = 1'b0;
  int dly = 0;
  initial begin
    forever begin
      @(negedge clk);
      if (auto_done) begin
        if (done_chk) begin
          check("done_busy", busy, 0);
          check("done_count", pair_count, 0);
          check("done_ready", in_ready, 1);
          done_chk = 1'b0;
        end
        dsp_done = 1'b0;
        if (start) dly = $urandom_range(0, 8);
        else if (busy) begin
          if (dly == 0) begin dsp_done = 1'b1; done_chk = 1'b1; end
          else dly--;
        end
      end
    end
  end

  // driver: call at a negedge; returns at a negedge after the byte's effects are checked
  task automatic send_byte(input logic [DATA_W-1:0] d, input bit last, input int gap);
    int waited = 0;
    bit was_b;
    bit ends = 0;
    repeat (gap) @(negedge clk);
    in_valid = 1'b1; in_data = d; in_last = last;
    while (!in_ready && waited < 300) begin @(negedge clk); waited++; end
    last_wait = waited;
    if (!in_ready) begin
      check("hold_timeout", in_ready, 1);
      in_valid = 1'b0; in_last = 1'b0;
      return;
    end
    was_b = have_a;
    if (!have_a) begin
      if (last) begin
        exp_err++;
        if (cnt > 0) begin start_q.push_back(cnt[ADDR_W:0]); cnt = 0; ends = 1; end
      end else begin
        model_a = d; have_a = 1;
      end
    end else begin
      exp_q.push_back({cnt[ADDR_W-1:0], model_a, d});
      cnt++;
      have_a = 0;
      if (last || cnt == DEPTH) begin start_q.push_back(cnt[ADDR_W:0]); cnt = 0; ends = 1; end
    end
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
    if (was_b) begin
      check("wr_latency", wr_en, 1);
      if (ends) begin @(negedge clk); check("start_latency", start, 1); end
    end else if (last) begin
      check("err_latency", err_odd, 1);
      check("start_odd", start, 32'(ends));
      if (!ends) check("ready_odd", in_ready, 1);
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("rst_outs", {in_ready, wr_en, wr_addr, wr_data_a, wr_data_b, start, pair_count, busy, err_odd}, 0);
    exp_q.delete(); start_q.delete();
    exp_err = 0; have_a = 0; cnt = 0;
    in_valid = 1'b0; in_last = 1'b0; dsp_done = 1'b0; done_chk = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    check("rel_idle", dbg_state, 0);
    @(negedge clk);
    check("rel_load_a", in_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // reset state
    #3;
    check("reset_outs", {in_ready, wr_en, wr_addr, wr_data_a, wr_data_b, start, pair_count, busy, err_odd}, 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    @(negedge clk); @(negedge clk);
    check("ready_after_reset", in_ready, 1);

    // two-pair run
    send_byte(8'h03, 0, 0); send_byte(8'h04, 0, 0);
    send_byte(8'h05, 0, 1); send_byte(8'h06, 1, 0);

    // full run without in_last, then a held 33rd byte
    for (int i = 0; i < 2*DEPTH; i++) send_byte(8'($urandom), 0, $urandom_range(0, 1));
    send_byte(8'($urandom), 0, 0);
    check("byte33_held", 32'(last_wait > 0), 1);
    send_byte(8'($urandom), 1, 0);

    // pair then odd last byte
    send_byte(8'h01, 0, 2); send_byte(8'h02, 0, 0); send_byte(8'h07, 1, 0);

    // lone odd byte in an empty run
    repeat (12) @(negedge clk);
    send_byte(8'h09, 1, 0);
    @(negedge clk);
    check("odd_empty_busy", busy, 0);

    // WAIT holds off a valid byte; done during START ignored; done outside WAIT ignored
    auto_done = 1'b0;
    send_byte(8'h11, 0, 0); send_byte(8'h22, 1, 0);
    dsp_done = 1'b1;
    @(negedge clk);
    dsp_done = 1'b0;
    check("done_in_start_ignored", busy, 1);
    in_valid = 1'b1; in_data = 8'hAA; in_last = 1'b0;
    for (int i = 0; i < 10; i++) begin
      check("wait_ready", in_ready, 0);
      @(negedge clk);
    end
    dsp_done = 1'b1;
    @(negedge clk);
    dsp_done = 1'b0; in_valid = 1'b0;
    check("wait_done_busy", busy, 0);
    check("wait_done_count", pair_count, 0);
    check("wait_done_ready", in_ready, 1);
    dsp_done = 1'b1;
    @(negedge clk);
    dsp_done = 1'b0;
    check("done_idle_ignored", {busy, in_ready}, 2'b01);
    auto_done = 1'b1;

    // random runs
    for (int r = 0; r < 8; r++) begin
      n = $urandom_range(1, 2*DEPTH);
      for (int i = 0; i < n; i++) send_byte(8'($urandom), i == n-1, $urandom_range(0, 2));
    end

    // async reset mid-LOAD_B
    repeat (12) @(negedge clk);
    send_byte(8'h55, 0, 0);
    do_reset();
    send_byte(8'h66, 0, 0); send_byte(8'h77, 1, 0);

    // async reset mid-WAIT
    repeat (12) @(negedge clk);
    auto_done = 1'b0;
    send_byte(8'h31, 0, 0); send_byte(8'h32, 0, 0);
    send_byte(8'h33, 0, 0); send_byte(8'h34, 1, 0);
    @(negedge clk);
    check("in_wait", busy, 1);
    do_reset();
    auto_done = 1'b1;
    send_byte(8'hA1, 0, 0); send_byte(8'hB2, 1, 0);

    repeat (20) @(negedge clk);
    check("exp_q_empty", exp_q.size(), 0);
    check("start_q_empty", start_q.size(), 0);
    check("err_all_seen", exp_err, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
